// File: rtl/led_pwm_driver.sv
// N-channel LED driver: per-channel off/steady/blink/breathe PWM with duty and mode
// double-buffered to the PWM period boundary, plus a trap override and selectable polarity.
module led_pwm_driver #(
  parameter int CHANNELS      = 5,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 188,
  parameter int BLINK_PERIODS = 250,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic                                              cfg_we_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch_i,
  input  logic [1:0]                                        cfg_mode_i,
  input  logic [PWM_BITS-1:0]                               cfg_duty_i,
  input  logic                                              trap_i,
  output logic [CHANNELS-1:0]                               led_o
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic POL = (ACTIVE_LOW != 0);

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_STEADY = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_BREATH = 2'b11;

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                ramp_down_q, ramp_down_d;
  logic                tick, period_end;

  logic [1:0]          sh_mode_q  [CHANNELS];
  logic [1:0]          sh_mode_d  [CHANNELS];
  logic [PWM_BITS-1:0] sh_duty_q  [CHANNELS];
  logic [PWM_BITS-1:0] sh_duty_d  [CHANNELS];
  logic [1:0]          act_mode_q [CHANNELS];
  logic [1:0]          act_mode_d [CHANNELS];
  logic [PWM_BITS-1:0] act_duty_q [CHANNELS];
  logic [PWM_BITS-1:0] act_duty_d [CHANNELS];

  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] lit;
  logic [CHANNELS-1:0] led_q, led_d;

  function automatic logic [PWM_BITS-1:0] min_u(input logic [PWM_BITS-1:0] a,
                                               input logic [PWM_BITS-1:0] b);
    return (a < b) ? a : b;
  endfunction

  always_comb begin
    tick          = (presc_q == PS_W'(PRESCALE - 1));
    period_end    = tick && (pwm_q == PWM_MAX);
    presc_d       = tick ? '0 : presc_q + 1'b1;
    pwm_d         = tick ? pwm_q + 1'b1 : pwm_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    ramp_d        = ramp_q;
    ramp_down_d   = ramp_down_q;
    if (period_end) begin
      if (blink_cnt_q == BL_W'(BLINK_PERIODS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
      // Direction flips on the step that lands on an endpoint, so no endpoint repeats.
      if (!ramp_down_q) begin
        ramp_d = ramp_q + 1'b1;
        if (ramp_q == PWM_MAX - 1'b1) ramp_down_d = 1'b1;
      end else begin
        ramp_d = ramp_q - 1'b1;
        if (ramp_q == PWM_BITS'(1)) ramp_down_d = 1'b0;
      end
    end
  end

  // Active registers load from the shadow's next value, so a write on period_end lands directly.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i]     = cfg_we_i && (cfg_ch_i == CH_W'(i));
      sh_mode_d[i]  = wr_hit[i] ? cfg_mode_i : sh_mode_q[i];
      sh_duty_d[i]  = wr_hit[i] ? cfg_duty_i : sh_duty_q[i];
      act_mode_d[i] = period_end ? sh_mode_d[i] : act_mode_q[i];
      act_duty_d[i] = period_end ? sh_duty_d[i] : act_duty_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      lit[i] = 1'b0;
      case (act_mode_q[i])
        MODE_OFF:    lit[i] = 1'b0;
        MODE_STEADY: lit[i] = (pwm_q < act_duty_q[i]);
        MODE_BLINK:  lit[i] = blink_phase_q && (pwm_q < act_duty_q[i]);
        MODE_BREATH: lit[i] = (pwm_q < min_u(ramp_q, act_duty_q[i]));
        default:     lit[i] = 1'b0;
      endcase
    end
    led_d = (trap_i ? {CHANNELS{blink_phase_q}} : lit) ^ {CHANNELS{POL}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q       <= '0;
      pwm_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      ramp_q        <= '0;
      ramp_down_q   <= 1'b0;
      led_q         <= {CHANNELS{POL}};
      for (int i = 0; i < CHANNELS; i++) begin
        sh_mode_q[i]  <= '0;
        sh_duty_q[i]  <= '0;
        act_mode_q[i] <= '0;
        act_duty_q[i] <= '0;
      end
    end else begin
      presc_q       <= presc_d;
      pwm_q         <= pwm_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      ramp_q        <= ramp_d;
      ramp_down_q   <= ramp_down_d;
      led_q         <= led_d;
      for (int i = 0; i < CHANNELS; i++) begin
        sh_mode_q[i]  <= sh_mode_d[i];
        sh_duty_q[i]  <= sh_duty_d[i];
        act_mode_q[i] <= act_mode_d[i];
        act_duty_q[i] <= act_duty_d[i];
      end
    end
  end

  assign led_o = led_q;

endmodule
